// File: rtl/shift_register_piso_tx.sv
// Parallel-in, serial-out transmitter. Accepts a word through a valid/ready
// load handshake and emits it on dout, one bit per enabled edge.
module shift_register_piso_tx #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic                         load_valid,
    output logic                         load_ready,
    input  logic [WIDTH-1:0]             data_in,
    output logic                         dout,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(WIDTH+1)-1:0]   bit_cnt
);

    localparam int CW = $clog2(WIDTH+1);

    // Handshake: a word moves on a rising edge where load_valid && load_ready;
    // load_ready is high only in IDLE, and load_valid is ignored otherwise.
    typedef enum logic {IDLE, SHIFT} state_e;

    state_e           state_q, state_d;
    // Holds only the bits not yet presented; the current bit lives in dout_q.
    logic [WIDTH-2:0] shreg_q, shreg_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             dout_q, dout_d;
    logic             done_q, done_d;
    logic             last_bit;
    logic             consume;
    logic             accept;

    assign last_bit = (bit_cnt_q == CW'(WIDTH - 1));
    assign consume  = (state_q == SHIFT) && enable;
    assign accept   = (state_q == IDLE) && load_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load_valid) state_d = SHIFT;
            SHIFT:   if (enable && last_bit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load_ready = (state_q == IDLE);
        busy       = (state_q == SHIFT);
    end

    always_comb begin
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        dout_d    = dout_q;
        done_d    = 1'b0;
        if (accept) begin
            bit_cnt_d = '0;
            if (MSB_FIRST) begin
                dout_d  = data_in[WIDTH-1];
                shreg_d = data_in[WIDTH-2:0];
            end else begin
                dout_d  = data_in[0];
                shreg_d = data_in[WIDTH-1:1];
            end
        end else if (consume) begin
            if (last_bit) begin
                bit_cnt_d = '0;
                dout_d    = 1'b0;
                done_d    = 1'b1;
                shreg_d   = '0;
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (MSB_FIRST) begin
                    dout_d  = shreg_q[WIDTH-2];
                    shreg_d = shreg_q << 1;
                end else begin
                    dout_d  = shreg_q[0];
                    shreg_d = shreg_q >> 1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            dout_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            dout_q    <= dout_d;
            done_q    <= done_d;
        end
    end

    assign dout    = dout_q;
    assign done    = done_q;
    assign bit_cnt = bit_cnt_q;

endmodule
